// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: source indices, write-source codes and age-rank helpers for the writeback arbiter
package reg_wb_arbiter_pkg;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC = 2'd2} src_e;
  localparam int NSRC = 3;
  localparam logic [2:0] REG_w_src_ALU    = 3'd0;
  localparam logic [2:0] REG_w_src_MEM    = 3'd1;
  localparam logic [2:0] REG_w_src_PC_inc = 3'd2;
  function automatic logic [2:0] src_code(input int idx);
    return idx == int'(SRC_MEM) ? REG_w_src_MEM :
           idx == int'(SRC_PC)  ? REG_w_src_PC_inc : REG_w_src_ALU;
  endfunction
  function automatic logic [1:0] age_rank(input int idx);
    return idx == int'(SRC_MEM) ? 2'd2 : idx == int'(SRC_ALU) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: producer request/ready channels and regfile write port of the writeback arbiter
interface reg_wb_arbiter_if #(parameter int DW = 32, parameter int AW = 5);
  logic          wb_stall;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          pc_valid, pc_ready;
  logic [AW-1:0] pc_waddr;
  logic [DW-1:0] pc_wdata;
  logic          reg_we;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic [2:0]    reg_w_src;
  logic [2:0]    wb_pending;
  modport slave (
    input  wb_stall,
    input  alu_valid, alu_waddr, alu_wdata, output alu_ready,
    input  mem_valid, mem_waddr, mem_wdata, output mem_ready,
    input  pc_valid,  pc_waddr,  pc_wdata,  output pc_ready,
    output reg_we, reg_waddr, reg_wdata, reg_w_src, wb_pending
  );
  modport master (
    output wb_stall,
    output alu_valid, alu_waddr, alu_wdata, input alu_ready,
    output mem_valid, mem_waddr, mem_wdata, input mem_ready,
    output pc_valid,  pc_waddr,  pc_wdata,  input pc_ready,
    input  reg_we, reg_waddr, reg_wdata, reg_w_src, wb_pending
  );
endinterface

// File: rtl/reg_wb_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding slot with full flag and same-cycle refill ready
module wb_slot #(parameter int DW = 32, parameter int AW = 5) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic          bypass,
  input  logic          grant,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          load,
  output logic          full,
  output logic [AW-1:0] q_waddr,
  output logic [DW-1:0] q_wdata
);
  logic          full_d, full_q;
  logic [AW-1:0] waddr_d, waddr_q;
  logic [DW-1:0] wdata_d, wdata_q;
  // A granted slot frees this edge, so it may be refilled at the same time; a bypassed request skips the slot.
  always_comb begin
    ready   = !full_q || grant;
    load    = valid && ready && !bypass;
    full_d  = load || (full_q && !grant);
    waddr_d = load ? waddr : waddr_q;
    wdata_d = load ? wdata : wdata_q;
  end
  // Slot state; reset discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      full_q  <= full_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign full    = full_q;
  assign q_waddr = waddr_q;
  assign q_wdata = wdata_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: oldest-first arbitration of ALU/MEM/PC writebacks onto one regfile port (WB_BYPASS_EN: empty-slot bypass)
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(parameter int DW = 32, parameter int AW = 5) (
  input logic clk,
  input logic rst_n,
  reg_wb_arbiter_if.slave wb
);
  logic [2:0]      valid, ready, full, grant, load, bypass, oldest, sel;
  logic [AW-1:0]   in_waddr [NSRC];
  logic [AW-1:0]   slot_waddr [NSRC];
  logic [DW-1:0]   in_wdata [NSRC];
  logic [DW-1:0]   slot_wdata [NSRC];
  logic [2:0][2:0] older_d, older_q;
  logic [AW-1:0]   sel_waddr;
  logic [DW-1:0]   sel_wdata;
  logic [2:0]      sel_src;
  logic            reg_we_d, reg_we_q;
  logic [AW-1:0]   reg_waddr_d, reg_waddr_q;
  logic [DW-1:0]   reg_wdata_d, reg_wdata_q;
  logic [2:0]      reg_w_src_d, reg_w_src_q;
  assign valid       = {wb.pc_valid, wb.mem_valid, wb.alu_valid};
  assign in_waddr[0] = wb.alu_waddr;
  assign in_waddr[1] = wb.mem_waddr;
  assign in_waddr[2] = wb.pc_waddr;
  assign in_wdata[0] = wb.alu_wdata;
  assign in_wdata[1] = wb.mem_wdata;
  assign in_wdata[2] = wb.pc_wdata;
  assign wb.alu_ready  = ready[0];
  assign wb.mem_ready  = ready[1];
  assign wb.pc_ready   = ready[2];
  assign wb.wb_pending = full;
  assign wb.reg_we     = reg_we_q;
  assign wb.reg_waddr  = reg_waddr_q;
  assign wb.reg_wdata  = reg_wdata_q;
  assign wb.reg_w_src  = reg_w_src_q;
  for (genvar i = 0; i < NSRC; i++) begin : g_slot
    wb_slot #(.DW(DW), .AW(AW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid[i]),
      .bypass  (bypass[i]),
      .grant   (grant[i]),
      .waddr   (in_waddr[i]),
      .wdata   (in_wdata[i]),
      .ready   (ready[i]),
      .load    (load[i]),
      .full    (full[i]),
      .q_waddr (slot_waddr[i]),
      .q_wdata (slot_wdata[i])
    );
  end
  // Grant the full slot older than every other full slot; bypass is only possible with nothing queued.
  always_comb begin
    oldest = 3'b000;
    for (int i = 0; i < NSRC; i++)
      oldest[i] = full[i] && &(older_q[i] | ~full | 3'(1 << i));
    grant = wb.wb_stall ? 3'b000 : oldest & (~oldest + 3'd1);
`ifdef WB_BYPASS_EN
    bypass = (wb.wb_stall || |full) ? 3'b000 :
             valid[1] ? 3'b010 : valid[0] ? 3'b001 : valid[2] ? 3'b100 : 3'b000;
`else
    bypass = 3'b000;
`endif
    sel = |grant ? grant : bypass;
  end
  // A loading entry is younger than every slot that stays full; simultaneous loads rank MEM > ALU > PC.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NSRC; i++)
      for (int j = 0; j < NSRC; j++)
        older_d[i][j] = (i == j) ? 1'b0 :
                        (load[i] && load[j]) ? (age_rank(i) > age_rank(j)) :
                        load[i] ? !(full[j] && !grant[j]) :
                        load[j] ? (full[i] && !grant[i]) : older_q[i][j];
  end
  // Next write-port value from the granted slot or the bypassed request; $0 is consumed without a write.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    sel_src   = REG_w_src_ALU;
    for (int i = 0; i < NSRC; i++)
      if (sel[i]) begin
        sel_waddr = grant[i] ? slot_waddr[i] : in_waddr[i];
        sel_wdata = grant[i] ? slot_wdata[i] : in_wdata[i];
        sel_src   = src_code(i);
      end
    reg_we_d    = |sel && (sel_waddr != '0);
    reg_waddr_d = |sel ? sel_waddr : reg_waddr_q;
    reg_wdata_d = |sel ? sel_wdata : reg_wdata_q;
    reg_w_src_d = |sel ? sel_src : reg_w_src_q;
  end
  // Age matrix and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q     <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_w_src_q <= REG_w_src_ALU;
    end else begin
      older_q     <= older_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_w_src_q <= reg_w_src_d;
    end
  end
endmodule
